// File: rtl/tdc_pkg.sv
// Shared types and default widths for the TDC measurement sequencer.
// The result struct carries one completed measurement at the default widths.
package tdc_pkg;

  localparam int COARSE_W_DEF = 16;
  localparam int FINE_W_DEF   = 8;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ARMED   = 3'd1,
    CAPTURE = 3'd2,
    OUTPUT  = 3'd3,
    DEAD    = 3'd4
  } tdc_state_e;

  typedef struct packed {
    logic                    timeout;
    logic [COARSE_W_DEF-1:0] coarse;
    logic [FINE_W_DEF-1:0]   fine;
  } tdc_result_t;

endpackage

// File: rtl/tdc_coarse_counter.sv
// Coarse cycle counter with synchronous clear, enable and an equality flag
// against a latched limit; it parks at the limit instead of wrapping.
module tdc_coarse_counter
  import tdc_pkg::*;
#(
  parameter int COARSE_W = COARSE_W_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                clear,
  input  logic                enable,
  input  logic [COARSE_W-1:0] limit,
  output logic [COARSE_W-1:0] count,
  output logic                at_limit
);

  assign at_limit = (count == limit);

  // Holding at the limit keeps an all-ones timeout from rolling over to zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !at_limit) begin
      count <= count + COARSE_W'(1);
    end
  end

endmodule

// File: rtl/tdc_meas_ctrl.sv
// Measurement sequencer for one TDC channel: arms the hit path, times the stop
// in coarse cycles, captures the fine code and hands the result to readout.
module tdc_meas_ctrl
  import tdc_pkg::*;
#(
  parameter int COARSE_W = COARSE_W_DEF,
  parameter int FINE_W   = FINE_W_DEF,
  parameter int DEAD_CYC = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic [COARSE_W-1:0] timeout_cfg,
  input  logic                sf_valid,
  input  logic                sf_finish,
  input  logic [FINE_W-1:0]   fine_code,
  output logic                arm,
  output logic                busy,
  output logic                res_valid,
  input  logic                res_ready,
  output logic [COARSE_W-1:0] res_coarse,
  output logic [FINE_W-1:0]   res_fine,
  output logic                res_timeout,
  output logic                err_start,
  output logic                err_stray,
  output logic                err_proto
);

  localparam int DEAD_W = (DEAD_CYC > 0) ? $clog2(DEAD_CYC + 1) : 1;
  localparam logic [DEAD_W-1:0] DEAD_LAST = DEAD_W'((DEAD_CYC > 0) ? DEAD_CYC - 1 : 0);

  tdc_state_e          state_q, state_d;
  logic [COARSE_W-1:0] limit_q;
  logic [COARSE_W-1:0] count;
  logic                at_limit;
  logic                cnt_clear, cnt_en;
  logic                latch_limit, cap_stop, cap_tmo, proto_d;
  logic                cap_cnt_q, cap_cnt_d;
  logic [DEAD_W-1:0]   dead_cnt_q, dead_cnt_d;

  tdc_coarse_counter #(
    .COARSE_W (COARSE_W)
  ) u_coarse (
    .clk      (clk),
    .rst      (rst),
    .clear    (cnt_clear),
    .enable   (cnt_en),
    .limit    (limit_q),
    .count    (count),
    .at_limit (at_limit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cap_cnt_q  <= 1'b0;
      dead_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      cap_cnt_q  <= cap_cnt_d;
      dead_cnt_q <= dead_cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cnt_clear   = 1'b0;
    cnt_en      = 1'b0;
    latch_limit = 1'b0;
    cap_stop    = 1'b0;
    cap_tmo     = 1'b0;
    proto_d     = 1'b0;
    cap_cnt_d   = cap_cnt_q;
    dead_cnt_d  = dead_cnt_q;
    unique case (state_q)
      IDLE: begin
        cnt_clear = 1'b1;
        if (start) begin
          latch_limit = 1'b1;
          state_d     = ARMED;
        end
      end
      ARMED: begin
        cnt_en = 1'b1;
        // A stop seen in the limit cycle is still a real hit, so it wins.
        if (sf_valid) begin
          cap_stop  = 1'b1;
          cap_cnt_d = 1'b0;
          state_d   = CAPTURE;
        end else if (at_limit) begin
          cap_tmo = 1'b1;
          state_d = OUTPUT;
        end
      end
      CAPTURE: begin
        if (sf_finish) begin
          state_d = OUTPUT;
        end else if (cap_cnt_q) begin
          proto_d = 1'b1;
          state_d = OUTPUT;
        end else begin
          cap_cnt_d = 1'b1;
        end
      end
      OUTPUT: begin
        // res_valid is high throughout OUTPUT, so ready alone completes the handshake.
        if (res_ready) begin
          dead_cnt_d = '0;
          state_d    = (DEAD_CYC == 0) ? IDLE : DEAD;
        end
      end
      DEAD: begin
        if (dead_cnt_q == DEAD_LAST) begin
          state_d = IDLE;
        end else begin
          dead_cnt_d = dead_cnt_q + DEAD_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      arm         <= 1'b0;
      busy        <= 1'b0;
      res_valid   <= 1'b0;
      res_coarse  <= '0;
      res_fine    <= '0;
      res_timeout <= 1'b0;
      err_start   <= 1'b0;
      err_stray   <= 1'b0;
      err_proto   <= 1'b0;
      limit_q     <= '0;
    end else begin
      arm       <= (state_d == ARMED);
      busy      <= (state_d != IDLE);
      res_valid <= (state_d == OUTPUT);
      err_start <= start && (state_q != IDLE);
      err_stray <= sf_valid && ((state_q == IDLE) || (state_q == DEAD));
      err_proto <= proto_d;
      if (latch_limit) begin
        limit_q <= timeout_cfg;
      end
      if (cap_stop) begin
        res_coarse  <= count;
        res_fine    <= fine_code;
        res_timeout <= 1'b0;
      end else if (cap_tmo) begin
        res_coarse  <= limit_q;
        res_fine    <= '0;
        res_timeout <= 1'b1;
      end
    end
  end

endmodule
